// File: rtl/cmp_result_tracker.sv
// On-line checker and statistics collector for the 4-bit magnitude comparator.
// All outputs registered (1-cycle latency); always ready, no backpressure.
module cmp_result_tracker #(
  parameter int WIDTH   = 4,
  parameter int CNT_W   = 8,
  parameter int RUN_LEN = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ceq,
  input  logic             clt,
  input  logic             cgt,
  input  logic             clear,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [WIDTH-1:0] min_val,
  output logic [WIDTH-1:0] max_val,
  output logic             any_seen,
  output logic [1:0]       last_res,
  output logic             run_alert,
  output logic             err_onehot,
  output logic             err_mismatch
);

  typedef enum logic {IDLE, TRACK} state_t;

  localparam logic [1:0] RES_EQ = 2'b01;
  localparam logic [1:0] RES_LT = 2'b10;
  localparam logic [1:0] RES_GT = 2'b11;
  localparam logic [7:0] RUN_MAX = 8'(RUN_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
  logic [CNT_W-1:0] lt_cnt_q, lt_cnt_d;
  logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d;
  logic [WIDTH-1:0] min_val_q, min_val_d;
  logic [WIDTH-1:0] max_val_q, max_val_d;
  logic             any_seen_q, any_seen_d;
  logic [1:0]       last_res_q, last_res_d;
  logic [7:0]       run_q, run_d;
  logic             run_alert_q, run_alert_d;
  logic             err_onehot_q, err_onehot_d;
  logic             err_mismatch_q, err_mismatch_d;

  logic             is_onehot;
  logic [1:0]       cmp_res;
  logic [1:0]       flag_res;
  logic [WIDTH-1:0] samp_lo;
  logic [WIDTH-1:0] samp_hi;

  assign is_onehot = ({ceq, clt, cgt} == 3'b100) || ({ceq, clt, cgt} == 3'b010) ||
                     ({ceq, clt, cgt} == 3'b001);
  assign cmp_res   = (a == b) ? RES_EQ : ((a < b) ? RES_LT : RES_GT);
  assign flag_res  = ceq ? RES_EQ : (clt ? RES_LT : RES_GT);
  assign samp_lo   = (a < b) ? a : b;
  assign samp_hi   = (a < b) ? b : a;

  always_comb begin
    state_d        = state_q;
    eq_cnt_d       = eq_cnt_q;
    lt_cnt_d       = lt_cnt_q;
    gt_cnt_d       = gt_cnt_q;
    min_val_d      = min_val_q;
    max_val_d      = max_val_q;
    any_seen_d     = any_seen_q;
    last_res_d     = last_res_q;
    run_d          = run_q;
    run_alert_d    = 1'b0;
    err_onehot_d   = err_onehot_q;
    err_mismatch_d = err_mismatch_q;

    if (clear) begin
      state_d        = IDLE;
      eq_cnt_d       = '0;
      lt_cnt_d       = '0;
      gt_cnt_d       = '0;
      min_val_d      = '0;
      max_val_d      = '0;
      any_seen_d     = 1'b0;
      last_res_d     = 2'b00;
      run_d          = '0;
      err_onehot_d   = 1'b0;
      err_mismatch_d = 1'b0;
    end else if (in_valid) begin
      if (!is_onehot) begin
        err_onehot_d = 1'b1;
        run_d        = '0;
      end else if (flag_res != cmp_res) begin
        err_mismatch_d = 1'b1;
        run_d          = '0;
      end else begin
        unique case (cmp_res)
          RES_EQ:  eq_cnt_d = (eq_cnt_q == CNT_SAT) ? eq_cnt_q : eq_cnt_q + CNT_ONE;
          RES_LT:  lt_cnt_d = (lt_cnt_q == CNT_SAT) ? lt_cnt_q : lt_cnt_q + CNT_ONE;
          default: gt_cnt_d = (gt_cnt_q == CNT_SAT) ? gt_cnt_q : gt_cnt_q + CNT_ONE;
        endcase
        if (state_q == IDLE) begin
          min_val_d = samp_lo;
          max_val_d = samp_hi;
        end else begin
          min_val_d = (samp_lo < min_val_q) ? samp_lo : min_val_q;
          max_val_d = (samp_hi > max_val_q) ? samp_hi : max_val_q;
        end
        // last_res is 00 after reset/clear, so the first result always starts a new run
        if (cmp_res == last_res_q) begin
          run_d = (run_q >= RUN_MAX) ? RUN_MAX : run_q + 8'd1;
        end else begin
          run_d = 8'd1;
        end
        run_alert_d = (run_d == RUN_MAX) && (run_q != RUN_MAX);
        last_res_d  = cmp_res;
        any_seen_d  = 1'b1;
        state_d     = TRACK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      eq_cnt_q       <= '0;
      lt_cnt_q       <= '0;
      gt_cnt_q       <= '0;
      min_val_q      <= '0;
      max_val_q      <= '0;
      any_seen_q     <= 1'b0;
      last_res_q     <= 2'b00;
      run_q          <= '0;
      run_alert_q    <= 1'b0;
      err_onehot_q   <= 1'b0;
      err_mismatch_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      eq_cnt_q       <= eq_cnt_d;
      lt_cnt_q       <= lt_cnt_d;
      gt_cnt_q       <= gt_cnt_d;
      min_val_q      <= min_val_d;
      max_val_q      <= max_val_d;
      any_seen_q     <= any_seen_d;
      last_res_q     <= last_res_d;
      run_q          <= run_d;
      run_alert_q    <= run_alert_d;
      err_onehot_q   <= err_onehot_d;
      err_mismatch_q <= err_mismatch_d;
    end
  end

  assign eq_cnt       = eq_cnt_q;
  assign lt_cnt       = lt_cnt_q;
  assign gt_cnt       = gt_cnt_q;
  assign min_val      = min_val_q;
  assign max_val      = max_val_q;
  assign any_seen     = any_seen_q;
  assign last_res     = last_res_q;
  assign run_alert    = run_alert_q;
  assign err_onehot   = err_onehot_q;
  assign err_mismatch = err_mismatch_q;

endmodule

// File: tb/tb_cmp_result_tracker.sv
// Randomized and directed bench for cmp_result_tracker against a behavioural model.
module tb_cmp_result_tracker;

  localparam int WIDTH   = 4;
  localparam int CNT_W   = 8;
  localparam int RUN_LEN = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             ceq = 1'b0;
  logic             clt = 1'b0;
  logic             cgt = 1'b0;
  logic             clear = 1'b0;
  logic [CNT_W-1:0] eq_cnt, lt_cnt, gt_cnt;
  logic [WIDTH-1:0] min_val, max_val;
  logic             any_seen;
  logic [1:0]       last_res;
  logic             run_alert, err_onehot, err_mismatch;

  cmp_result_tracker #(.WIDTH(WIDTH), .CNT_W(CNT_W), .RUN_LEN(RUN_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .ceq(ceq), .clt(clt), .cgt(cgt), .clear(clear),
    .eq_cnt(eq_cnt), .lt_cnt(lt_cnt), .gt_cnt(gt_cnt),
    .min_val(min_val), .max_val(max_val), .any_seen(any_seen),
    .last_res(last_res), .run_alert(run_alert),
    .err_onehot(err_onehot), .err_mismatch(err_mismatch)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state, kept as plain integers
  int m_cnt[1:3];
  int m_min, m_max, m_seen, m_last, m_run, m_alert, m_eoh, m_emm;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt[1] = 0; m_cnt[2] = 0; m_cnt[3] = 0;
    m_min = 0; m_max = 0; m_seen = 0; m_last = 0;
    m_run = 0; m_alert = 0; m_eoh = 0; m_emm = 0;
  endtask

  task automatic model_step(input int v, input int va, input int vb,
                            input int fe, input int fl, input int fg, input int clr);
    int truth, claimed, lo, hi, prev_run;
    m_alert = 0;
    if (clr != 0) begin
      model_reset();
    end else if (v != 0) begin
      truth   = (va == vb) ? 1 : ((va < vb) ? 2 : 3);
      claimed = fe ? 1 : (fl ? 2 : 3);
      if (fe + fl + fg != 1) begin
        m_eoh = 1;
        m_run = 0;
      end else if (claimed != truth) begin
        m_emm = 1;
        m_run = 0;
      end else begin
        if (m_cnt[truth] < CNT_MAX) m_cnt[truth]++;
        lo = (va < vb) ? va : vb;
        hi = (va < vb) ? vb : va;
        if (m_seen == 0) begin
          m_min = lo; m_max = hi;
        end else begin
          if (lo < m_min) m_min = lo;
          if (hi > m_max) m_max = hi;
        end
        prev_run = m_run;
        m_run    = (truth == m_last) ? ((m_run + 1 > RUN_LEN) ? RUN_LEN : m_run + 1) : 1;
        m_alert  = (m_run == RUN_LEN && prev_run < RUN_LEN) ? 1 : 0;
        m_last   = truth;
        m_seen   = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".eq_cnt"}, eq_cnt, m_cnt[1]);
    chk({tag, ".lt_cnt"}, lt_cnt, m_cnt[2]);
    chk({tag, ".gt_cnt"}, gt_cnt, m_cnt[3]);
    chk({tag, ".min_val"}, min_val, m_min);
    chk({tag, ".max_val"}, max_val, m_max);
    chk({tag, ".any_seen"}, any_seen, m_seen);
    chk({tag, ".last_res"}, last_res, m_last);
    chk({tag, ".run_alert"}, run_alert, m_alert);
    chk({tag, ".err_onehot"}, err_onehot, m_eoh);
    chk({tag, ".err_mismatch"}, err_mismatch, m_emm);
  endtask

  task automatic drive(input string tag, input int v, input int va, input int vb,
                       input int fe, input int fl, input int fg, input int clr);
    in_valid = v[0];
    a = va[WIDTH-1:0];
    b = vb[WIDTH-1:0];
    ceq = fe[0]; clt = fl[0]; cgt = fg[0];
    clear = clr[0];
    @(posedge clk);
    model_step(v, va, vb, fe, fl, fg, clr);
    #1;
    check_all(tag);
    in_valid = 1'b0;
    clear = 1'b0;
  endtask

  task automatic samp(input string tag, input int va, input int vb);
    drive(tag, 1, va, vb, (va == vb) ? 1 : 0, (va < vb) ? 1 : 0, (va > vb) ? 1 : 0, 0);
  endtask

  task automatic idle(input string tag);
    drive(tag, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int ra, rb, kind, fe, fl, fg;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle("post_reset");

    // Basic mixed sequence
    samp("tp1_eq", 4, 4);
    samp("tp1_lt", 2, 5);
    samp("tp1_gt", 7, 3);
    chk("tp1_min", min_val, 2);
    chk("tp1_max", max_val, 7);
    chk("tp1_last", last_res, 3);

    // Run detection with an idle gap inside the run
    drive("clr1", 0, 0, 0, 0, 0, 0, 1);
    samp("run_a", 5, 5);
    samp("run_b", 5, 5);
    idle("run_gap");
    samp("run_c", 5, 5);
    chk("run_pulse1", run_alert, 1);
    idle("run_after");
    chk("run_pulse_len", run_alert, 0);
    samp("run_d", 5, 5);
    chk("run_no_repulse", run_alert, 0);
    samp("run_lt", 2, 3);
    samp("run_e", 1, 1);
    samp("run_f", 9, 9);
    samp("run_g", 0, 0);
    chk("run_pulse2", run_alert, 1);

    // Protocol errors
    samp("err_pre", 4, 4);
    drive("err_onehot", 1, 6, 2, 1, 0, 1, 0);
    chk("err_onehot_flag", err_onehot, 1);
    samp("err_run_a", 4, 4);
    samp("err_run_b", 4, 4);
    chk("err_run_reset", run_alert, 0);
    drive("err_mm", 1, 1, 9, 0, 0, 1, 0);
    chk("err_mm_flag", err_mismatch, 1);

    // Counter saturation
    drive("clr2", 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 260; i++) begin
      ra = $urandom_range(0, 14);
      rb = $urandom_range(ra + 1, 15);
      samp("sat", ra, rb);
    end
    chk("sat_lt", lt_cnt, 255);

    // clear wins over a simultaneous sample
    drive("clr_pri", 1, 0, 15, 0, 1, 0, 1);
    chk("clr_pri_lt", lt_cnt, 0);
    samp("clr_first", 8, 8);
    chk("clr_min", min_val, 8);
    chk("clr_max", max_val, 8);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      ra = $urandom_range(0, 15);
      rb = (($urandom_range(0, 3) == 0)) ? ra : $urandom_range(0, 15);
      kind = $urandom_range(0, 19);
      fe = (ra == rb) ? 1 : 0;
      fl = (ra < rb) ? 1 : 0;
      fg = (ra > rb) ? 1 : 0;
      if (kind == 0) begin
        fe = $urandom_range(0, 1); fl = $urandom_range(0, 1); fg = $urandom_range(0, 1);
      end else if (kind == 1) begin
        fe = 0; fl = 0; fg = 0;
        case ($urandom_range(0, 2))
          0: fe = 1;
          1: fl = 1;
          default: fg = 1;
        endcase
      end
      drive("rand", (kind < 17) ? 1 : 0, ra, rb, fe, fl, fg, (kind == 19 && i % 7 == 0) ? 1 : 0);
    end

    // Asynchronous reset mid-stream
    drive("clr3", 0, 0, 0, 0, 0, 0, 1);
    samp("ar_a", 1, 2);
    samp("ar_b", 3, 9);
    samp("ar_c", 0, 4);
    drive("ar_bad", 1, 5, 5, 0, 0, 0, 0);
    chk("ar_pre_lt", lt_cnt, 3);
    chk("ar_pre_err", err_onehot, 1);
    @(negedge clk);
    in_valid = 1'b1; a = 4'd2; b = 4'd7; clt = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0; clt = 1'b0;
    idle("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cmp_result_tracker.md
Name: cmp_result_tracker

Overview:
- Downstream consumer of the 4-bit magnitude comparator.
- Samples each operand pair (a, b) together with the comparator's ceq/clt/cgt flags, checks the flags for protocol and arithmetic consistency, and keeps running statistics.
- Statistics kept: per-result counts, operand min/max, and consecutive-result run detection.
- Sits between the comparator and the status/monitor logic; acts as the comparator's on-line checker.

Parameters:
WIDTH, 4, operand width of a and b (matches the comparator)
CNT_W, 8, width of each result counter
RUN_LEN, 3, number of consecutive identical results that raises run_alert (legal range 2..255)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  a, b, ceq, clt, cgt valid this cycle
a  input  WIDTH  operand A presented to the comparator
b  input  WIDTH  operand B presented to the comparator
ceq  input  1  comparator equal flag
clt  input  1  comparator less-than flag (a<b)
cgt  input  1  comparator greater-than flag (a>b)
clear  input  1  synchronous clear of all statistics and errors
eq_cnt  output  CNT_W  accepted samples with result EQ, saturating
lt_cnt  output  CNT_W  accepted samples with result LT, saturating
gt_cnt  output  CNT_W  accepted samples with result GT, saturating
min_val  output  WIDTH  smallest operand (a or b) among accepted samples
max_val  output  WIDTH  largest operand (a or b) among accepted samples
any_seen  output  1  at least one sample accepted since reset/clear
last_res  output  2  last accepted result: 00 none, 01 EQ, 10 LT, 11 GT
run_alert  output  1  one-cycle pulse when the run of identical results reaches RUN_LEN
err_onehot  output  1  sticky: a sample with flags not exactly one-hot was seen
err_mismatch  output  1  sticky: a one-hot sample disagreed with the internal a/b comparison

Behaviour:
- Reset (rst_n=0, async): every output 0; FSM in IDLE; run counter 0. Reset applies immediately mid-operation and discards any pending update.
- Outputs are registered: a sample on edge N is reflected in the outputs after edge N. No combinational input-to-output path.
- FSM states:
  - IDLE: no accepted sample yet.
  - TRACK: at least one accepted sample.
  - IDLE->TRACK on the first accepted sample. Any->IDLE on clear.
- Sample classification when in_valid=1:
  - {ceq,clt,cgt} not exactly one-hot: set err_onehot; reject the sample.
  - One-hot but disagreeing with the unsigned compare of a and b: set err_mismatch; reject the sample.
  - Otherwise accept the sample.
- Rejected samples: counters, min/max, last_res and any_seen are unchanged; run counter resets to 0.
- Accepted sample:
  - Increment the matching counter, saturating at 2^CNT_W-1 (it holds, never wraps).
  - last_res updated.
  - any_seen=1.
- min/max:
  - First accepted sample (IDLE): min_val=min(a,b), max_val=max(a,b).
  - Later accepted samples: min_val=min(min_val,a,b), max_val=max(max_val,a,b). All comparisons are unsigned.
- Run tracking:
  - Accepted result equal to last_res: run=run+1, saturating at RUN_LEN.
  - Otherwise run=1.
  - run_alert=1 for exactly the one cycle after the edge on which run transitions to RUN_LEN. It does not re-pulse while the run continues. It re-arms only after a different result or a rejection.
  - in_valid=0 cycles do not break a run.
- Error flags are sticky until reset or clear. Both flags may be set by different samples.
- clear=1:
  - On the next edge, all outputs go to 0, run goes to 0, FSM goes to IDLE.
  - clear has priority over in_valid in the same cycle; that sample is dropped.
- in_valid=0: no state change, except that run_alert returns to 0.

Test Plan:
- Reset then samples (4,4,EQ),(2,5,LT),(7,3,GT) -> eq/lt/gt_cnt=1/1/1, min_val=2, max_val=7, last_res=11, no errors, run_alert never high.
- Three (5,5,EQ) samples with an idle cycle between the 2nd and 3rd -> run_alert high for one cycle after the 3rd edge; a 4th EQ gives no pulse; then LT then 3×EQ gives a second pulse.
- Sample (6,2) with ceq=1,cgt=1 -> err_onehot=1, counters unchanged, run reset; then (1,9,GT) -> err_mismatch=1, lt_cnt/gt_cnt unchanged.
- 260 accepted LT samples with CNT_W=8 -> lt_cnt holds at 255, no wrap.
- clear asserted in the same cycle as (0,15,LT) -> all outputs 0, FSM IDLE; the next (8,8,EQ) sets min_val=max_val=8.
- rst_n pulled low mid-stream (lt_cnt=3, err_onehot=1) -> all outputs 0 immediately, before the next clock edge.
